// File: rtl/person_pkg.sv
// Shared types, part geometry and the pos -> part-bounds helper for the person sprite.
package person_pkg;

  localparam int HEAD_W   = 16;
  localparam int HEAD_H   = 16;
  localparam int TORSO_W  = 24;
  localparam int TORSO_H  = 32;
  localparam int LEGS_W   = 24;
  localparam int LEGS_H   = 32;
  localparam int ARMS_W   = 40;
  localparam int ARMS_H   = 8;
  localparam int PERSON_W = 40;
  localparam int PERSON_H = 80;
  localparam int HEAD_XO  = 12;
  localparam int TORSO_XO = 8;
  localparam int LEGS_XO  = 8;
  localparam int ARM_YOFF = 4;

  typedef enum logic [1:0] {IDLE, RISE, FALL} jump_state_t;

  typedef struct packed {
    logic [9:0] hmin;
    logic [9:0] hmax;
    logic [9:0] vmin;
    logic [9:0] vmax;
  } box_t;

  typedef struct packed {
    box_t head;
    box_t torso;
    box_t legs;
    box_t arms;
  } bounds_t;

  function automatic box_t make_box(input logic [9:0] x0, input logic [9:0] y0,
                                    input logic [9:0] w, input logic [9:0] h);
    box_t b;
    b.hmin = x0;
    b.hmax = x0 + w - 10'd1;
    b.vmin = y0;
    b.vmax = y0 + h - 10'd1;
    return b;
  endfunction

  function automatic bounds_t calc_bounds(input logic [9:0] x, input logic [9:0] y,
                                          input logic [9:0] arm_yoff);
    bounds_t b;
    b.head  = make_box(x + 10'(HEAD_XO), y, 10'(HEAD_W), 10'(HEAD_H));
    b.torso = make_box(x + 10'(TORSO_XO), y + 10'(HEAD_H), 10'(TORSO_W), 10'(TORSO_H));
    b.legs  = make_box(x + 10'(LEGS_XO), y + 10'(HEAD_H + TORSO_H), 10'(LEGS_W), 10'(LEGS_H));
    b.arms  = make_box(x, y + 10'(HEAD_H) + arm_yoff, 10'(ARMS_W), 10'(ARMS_H));
    return b;
  endfunction

endpackage

// File: rtl/person_box_calc.sv
// Combinational position -> inclusive part bounds; the parent registers the result.
module person_box_calc
  import person_pkg::*;
(
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic [9:0] arm_yoff,
  output bounds_t    bounds
);

  always_comb begin
    bounds = calc_bounds(pos_x, pos_y, arm_yoff);
  end

endmodule

// File: rtl/person_pose_ctrl.sv
// Per-frame person position/jump controller driving part-box bounds.
// Optional arm swing animation enabled by defining ARMS_SWING_EN.
//
// state | meaning
// IDLE  | on the ground, jump_req on a frame tick starts a jump
// RISE  | moving up JUMP_DY per tick for JUMP_FRAMES ticks
// FALL  | moving down JUMP_DY per tick for JUMP_FRAMES ticks, then IDLE
module person_pose_ctrl
  import person_pkg::*;
#(
  parameter int X_INIT      = 300,
  parameter int Y_INIT      = 300,
  parameter int X_MAX       = 727,
  parameter int STEP_X      = 4,
  parameter int JUMP_FRAMES = 8,
  parameter int JUMP_DY     = 4
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       vblnk_in,
  input  logic       move_left,
  input  logic       move_right,
  input  logic       jump_req,
  output logic       jump_busy,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [9:0] HcountMinHead,
  output logic [9:0] HcountMaxHead,
  output logic [9:0] VcountMinHead,
  output logic [9:0] VcountMaxHead,
  output logic [9:0] HcountMinTorso,
  output logic [9:0] HcountMaxTorso,
  output logic [9:0] VcountMinTorso,
  output logic [9:0] VcountMaxTorso,
  output logic [9:0] HcountMinLegs,
  output logic [9:0] HcountMaxLegs,
  output logic [9:0] VcountMinLegs,
  output logic [9:0] VcountMaxLegs,
  output logic [9:0] HcountMinArms,
  output logic [9:0] HcountMaxArms,
  output logic [9:0] VcountMinArms,
  output logic [9:0] VcountMaxArms
);

  localparam logic [9:0] X_INIT10 = 10'(X_INIT);
  localparam logic [9:0] Y_INIT10 = 10'(Y_INIT);
  localparam logic [9:0] X_MAX10  = 10'(X_MAX);
  localparam logic [9:0] STEP10   = 10'(STEP_X);
  localparam logic [9:0] DY10     = 10'(JUMP_DY);
  localparam logic [7:0] CNT_LAST = 8'(JUMP_FRAMES - 1);

  if (Y_INIT < JUMP_FRAMES * JUMP_DY || Y_INIT + PERSON_H - 1 > 1023) begin : g_param_check
    $error("person_pose_ctrl: Y_INIT leaves no room for the jump or the body height");
  end

  logic        vblnk_q;
  logic        tick;
  logic [9:0]  x_next;
  logic [9:0]  arm_yoff;
  logic [7:0]  cnt;
  jump_state_t state;
  bounds_t     bounds_c;
  bounds_t     bounds_q;

  assign tick = vblnk_in & ~vblnk_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) vblnk_q <= 1'b0;
    else        vblnk_q <= vblnk_in;
  end

  always_comb begin
    x_next = pos_x;
    if (move_left && !move_right)
      x_next = (pos_x < STEP10) ? 10'd0 : pos_x - STEP10;
    else if (move_right && !move_left)
      x_next = (pos_x > X_MAX10 - STEP10) ? X_MAX10 : pos_x + STEP10;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pos_x     <= X_INIT10;
      pos_y     <= Y_INIT10;
      jump_busy <= 1'b0;
    end else if (tick) begin
      pos_x <= x_next;
      case (state)
        IDLE: begin
          if (jump_req) begin
            state     <= RISE;
            cnt       <= '0;
            jump_busy <= 1'b1;
          end
        end
        RISE: begin
          pos_y <= pos_y - DY10;
          if (cnt == CNT_LAST) begin
            state <= FALL;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        FALL: begin
          pos_y <= pos_y + DY10;
          if (cnt == CNT_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            jump_busy <= 1'b0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state     <= IDLE;
          jump_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef ARMS_SWING_EN
  // Counter wraps every 8 moves, so bit 2 flips the arm pose every 4 moves.
  logic [2:0] swing_cnt;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)    swing_cnt <= '0;
    else if (tick) swing_cnt <= (x_next != pos_x) ? swing_cnt + 3'd1 : 3'd0;
  end

  assign arm_yoff = swing_cnt[2] ? 10'(ARM_YOFF + 4) : 10'(ARM_YOFF);
`else
  assign arm_yoff = 10'(ARM_YOFF);
`endif

  person_box_calc u_box_calc (
    .pos_x    (pos_x),
    .pos_y    (pos_y),
    .arm_yoff (arm_yoff),
    .bounds   (bounds_c)
  );

  // Bounds follow the position register by one cycle and only change after a tick.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) bounds_q <= calc_bounds(X_INIT10, Y_INIT10, 10'(ARM_YOFF));
    else        bounds_q <= bounds_c;
  end

  assign HcountMinHead  = bounds_q.head.hmin;
  assign HcountMaxHead  = bounds_q.head.hmax;
  assign VcountMinHead  = bounds_q.head.vmin;
  assign VcountMaxHead  = bounds_q.head.vmax;
  assign HcountMinTorso = bounds_q.torso.hmin;
  assign HcountMaxTorso = bounds_q.torso.hmax;
  assign VcountMinTorso = bounds_q.torso.vmin;
  assign VcountMaxTorso = bounds_q.torso.vmax;
  assign HcountMinLegs  = bounds_q.legs.hmin;
  assign HcountMaxLegs  = bounds_q.legs.hmax;
  assign VcountMinLegs  = bounds_q.legs.vmin;
  assign VcountMaxLegs  = bounds_q.legs.vmax;
  assign HcountMinArms  = bounds_q.arms.hmin;
  assign HcountMaxArms  = bounds_q.arms.hmax;
  assign VcountMinArms  = bounds_q.arms.vmin;
  assign VcountMaxArms  = bounds_q.arms.vmax;

endmodule

// File: tb/tb_person_pose_ctrl.sv
// Self-checking bench for person_pose_ctrl (default build, ARMS_SWING_EN undefined).
module tb_person_pose_ctrl;

  logic       pclk = 1'b0;
  logic       rst_n;
  logic       vblnk_in;
  logic       move_left;
  logic       move_right;
  logic       jump_req;
  logic       jump_busy;
  logic [9:0] pos_x, pos_y;
  logic [9:0] HcountMinHead, HcountMaxHead, VcountMinHead, VcountMaxHead;
  logic [9:0] HcountMinTorso, HcountMaxTorso, VcountMinTorso, VcountMaxTorso;
  logic [9:0] HcountMinLegs, HcountMaxLegs, VcountMinLegs, VcountMaxLegs;
  logic [9:0] HcountMinArms, HcountMaxArms, VcountMinArms, VcountMaxArms;

  always #5 pclk = ~pclk;

  person_pose_ctrl dut (
    .pclk(pclk), .rst_n(rst_n), .vblnk_in(vblnk_in),
    .move_left(move_left), .move_right(move_right), .jump_req(jump_req),
    .jump_busy(jump_busy), .pos_x(pos_x), .pos_y(pos_y),
    .HcountMinHead(HcountMinHead), .HcountMaxHead(HcountMaxHead),
    .VcountMinHead(VcountMinHead), .VcountMaxHead(VcountMaxHead),
    .HcountMinTorso(HcountMinTorso), .HcountMaxTorso(HcountMaxTorso),
    .VcountMinTorso(VcountMinTorso), .VcountMaxTorso(VcountMaxTorso),
    .HcountMinLegs(HcountMinLegs), .HcountMaxLegs(HcountMaxLegs),
    .VcountMinLegs(VcountMinLegs), .VcountMaxLegs(VcountMaxLegs),
    .HcountMinArms(HcountMinArms), .HcountMaxArms(HcountMaxArms),
    .VcountMinArms(VcountMinArms), .VcountMaxArms(VcountMaxArms)
  );

  typedef struct {
    logic l;
    logic r;
    logic j;
    int   x;
    int   y;
    logic busy;
  } vec_t;

  typedef struct {
    int   x;
    int   y;
    logic busy;
  } exp_t;

  vec_t vecs[8];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: jump tracked as ticks elapsed since the trigger.
  int m_x, m_y, m_jk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 300; m_y = 300; m_jk = -1;
  endtask

  task automatic model_step(input logic l, input logic r, input logic j, output exp_t e);
    if (l && !r)      m_x = (m_x - 4 < 0) ? 0 : m_x - 4;
    else if (r && !l) m_x = (m_x + 4 > 727) ? 727 : m_x + 4;
    if (m_jk < 0) begin
      if (j) m_jk = 0;
    end else begin
      m_jk++;
      if (m_jk == 16) m_jk = -1;
    end
    if (m_jk < 0)       m_y = 300;
    else if (m_jk <= 8) m_y = 300 - 4 * m_jk;
    else                m_y = 300 - 4 * (16 - m_jk);
    e.x = m_x; e.y = m_y; e.busy = (m_jk >= 0);
  endtask

  task automatic compare_front();
    exp_t e;
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = sb.pop_front();
    check("pos_x", int'(pos_x), e.x);
    check("pos_y", int'(pos_y), e.y);
    check("jump_busy", int'(jump_busy), int'(e.busy));
    check("head_hmin", int'(HcountMinHead), e.x + 12);
    check("head_hmax", int'(HcountMaxHead), e.x + 27);
    check("head_vmin", int'(VcountMinHead), e.y);
    check("head_vmax", int'(VcountMaxHead), e.y + 15);
    check("torso_h", int'(HcountMinTorso) * 1024 + int'(HcountMaxTorso), (e.x + 8) * 1024 + e.x + 31);
    check("torso_v", int'(VcountMinTorso) * 1024 + int'(VcountMaxTorso), (e.y + 16) * 1024 + e.y + 47);
    check("legs_h", int'(HcountMinLegs) * 1024 + int'(HcountMaxLegs), (e.x + 8) * 1024 + e.x + 31);
    check("legs_v", int'(VcountMinLegs) * 1024 + int'(VcountMaxLegs), (e.y + 48) * 1024 + e.y + 79);
    check("arms_h", int'(HcountMinArms) * 1024 + int'(HcountMaxArms), e.x * 1024 + e.x + 39);
    check("arms_v", int'(VcountMinArms) * 1024 + int'(VcountMaxArms), (e.y + 20) * 1024 + e.y + 27);
  endtask

  // One frame tick; outputs sampled at the negedge after the second posedge.
  task automatic frame_tick(input logic l, input logic r, input logic j, input exp_t e);
    @(negedge pclk);
    move_left = l; move_right = r; jump_req = j;
    vblnk_in = 1'b1;
    sb.push_back(e);
    @(negedge pclk);
    vblnk_in = 1'b0;
    @(negedge pclk);
    compare_front();
    repeat (2) @(negedge pclk);
  endtask

  task automatic model_tick(input logic l, input logic r, input logic j);
    exp_t e;
    model_step(l, r, j, e);
    frame_tick(l, r, j, e);
  endtask

  task automatic do_reset();
    @(negedge pclk);
    rst_n = 1'b0;
    vblnk_in = 1'b0; move_left = 1'b0; move_right = 1'b0; jump_req = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
    @(negedge pclk);
  endtask

  initial begin
    exp_t e;
    vecs[0] = '{1'b0, 1'b1, 1'b0, 304, 300, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 308, 300, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 312, 300, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 312, 300, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 312, 300, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 308, 300, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 308, 300, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 304, 296, 1'b1};

    rst_n = 1'b0;
    vblnk_in = 1'b0; move_left = 1'b0; move_right = 1'b0; jump_req = 1'b0;
    do_reset();

    check("rst_pos_x", int'(pos_x), 300);
    check("rst_pos_y", int'(pos_y), 300);
    check("rst_busy", int'(jump_busy), 0);
    check("rst_head_h", int'(HcountMinHead) * 1024 + int'(HcountMaxHead), 312 * 1024 + 327);
    check("rst_head_v", int'(VcountMinHead) * 1024 + int'(VcountMaxHead), 300 * 1024 + 315);
    check("rst_torso_h", int'(HcountMinTorso) * 1024 + int'(HcountMaxTorso), 308 * 1024 + 331);
    check("rst_torso_v", int'(VcountMinTorso) * 1024 + int'(VcountMaxTorso), 316 * 1024 + 347);
    check("rst_legs_v", int'(VcountMinLegs) * 1024 + int'(VcountMaxLegs), 348 * 1024 + 379);
    check("rst_arms_h", int'(HcountMinArms) * 1024 + int'(HcountMaxArms), 300 * 1024 + 339);
    check("rst_arms_v", int'(VcountMinArms) * 1024 + int'(VcountMaxArms), 320 * 1024 + 327);

    for (int i = 0; i < 8; i++) begin
      e.x = vecs[i].x; e.y = vecs[i].y; e.busy = vecs[i].busy;
      frame_tick(vecs[i].l, vecs[i].r, vecs[i].j, e);
    end

    // Two-cycle latency: pos moves one cycle after the tick, bounds one cycle later.
    do_reset();
    @(negedge pclk);
    move_right = 1'b1; vblnk_in = 1'b1;
    @(negedge pclk);
    vblnk_in = 1'b0;
    check("lat_pos_x_t1", int'(pos_x), 304);
    check("lat_head_hmin_t1", int'(HcountMinHead), 312);
    @(negedge pclk);
    check("lat_head_hmin_t2", int'(HcountMinHead), 316);
    @(negedge pclk);
    check("lat_no_retick", int'(pos_x), 304);

    do_reset();
    for (int i = 1; i <= 80; i++) begin
      model_tick(1'b1, 1'b0, 1'b0);
      if (i == 74) check("sat_left_t74", int'(pos_x), 4);
      if (i == 75) check("sat_left_t75", int'(pos_x), 0);
    end
    model_tick(1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 183; i++) model_tick(1'b0, 1'b1, 1'b0);
    check("sat_right_max", int'(pos_x), 727);

    do_reset();
    for (int k = 1; k <= 19; k++) begin
      model_tick(1'b0, 1'b0, (k == 1 || k == 5 || k >= 18) ? 1'b1 : 1'b0);
      if (k == 9)  check("jump_apex_y", int'(pos_y), 268);
      if (k == 16) check("jump_busy_t16", int'(jump_busy), 1);
      if (k == 17) check("jump_land_y", int'(pos_y) * 2 + int'(jump_busy), 600);
      if (k == 18) check("jump_retrigger", int'(jump_busy), 1);
    end

    do_reset();
    model_tick(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) model_tick(1'b0, 1'b0, 1'b0);
    check("pre_rst_y", int'(pos_y), 284);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_y", int'(pos_y), 300);
    check("async_rst_busy", int'(jump_busy), 0);
    check("async_rst_head_vmin", int'(VcountMinHead), 300);
    @(negedge pclk);
    rst_n = 1'b1;
    model_reset();
    model_tick(1'b0, 1'b0, 1'b0);

    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
